leaf_stream_bridge: RTL and testbench
=====================================

Name: leaf_stream_bridge

Overview:
Parametrised, buffered bridge between the leaf_interface user-side vld/ack ports and the AXI-stream ports of an HLS kernel inside a leaf wrapper. It replaces direct wiring and the tied-off kernel start. The block adds per-channel elastic FIFOs, an ap_start-driven run/drain controller with idle/done status, and per-channel beat counters. Each leaf_N wrapper instantiates one bridge between leaf_interface and the kernel.

Parameters:
PAYLOAD_BITS, 32, data width of every channel
NUM_IN_PORTS, 2, channels from leaf_interface to kernel (1..8)
NUM_OUT_PORTS, 2, channels from kernel to leaf_interface (1..8)
FIFO_DEPTH, 4, entries per channel FIFO; power of two, >=2
COUNT_BITS, 16, width of each beat counter

Ports:
clk  in  1  clock
ap_rst_n  in  1  reset, asynchronous, active-low
ap_start  in  1  run request (level)
ap_idle  out  1  controller in IDLE
ap_done  out  1  one-cycle pulse on DRAIN->IDLE
dout_leaf_interface2user  in  NUM_IN_PORTS*PAYLOAD_BITS  inbound data, channel i at [i*PB +: PB]
vld_interface2user  in  NUM_IN_PORTS  inbound valid
ack_user2interface  out  NUM_IN_PORTS  inbound accept
in_tdata  out  NUM_IN_PORTS*PAYLOAD_BITS  to kernel Input_i TDATA
in_tvalid  out  NUM_IN_PORTS  to kernel TVALID
in_tready  in  NUM_IN_PORTS  from kernel TREADY
out_tdata  in  NUM_OUT_PORTS*PAYLOAD_BITS  from kernel Output_i TDATA
out_tvalid  in  NUM_OUT_PORTS  from kernel TVALID
out_tready  out  NUM_OUT_PORTS  to kernel TREADY
din_leaf_user2interface  out  NUM_OUT_PORTS*PAYLOAD_BITS  outbound data
vld_user2interface  out  NUM_OUT_PORTS  outbound valid
ack_interface2user  in  NUM_OUT_PORTS  outbound accept
in_beats  out  NUM_IN_PORTS*COUNT_BITS  inbound pushes per channel
out_beats  out  NUM_OUT_PORTS*COUNT_BITS  outbound pushes per channel

Behaviour:
- Reset (ap_rst_n low, async): all FIFOs empty, state IDLE, counters 0, ap_idle=1, ap_done=0. All ack/vld/tvalid/tready outputs are 0. Reset mid-transfer discards FIFO contents.
- Transfer rule on every interface: a beat moves on any rising edge where valid and accept are both 1. vld/ack follow the same rule as tvalid/tready.
- Inbound channel i: ack_user2interface[i] = (state==RUN) && !full_i. Push on vld&ack. in_tvalid[i] = !empty_i and in_tdata shows the head entry. Pop on in_tvalid&in_tready.
- Outbound channel j: out_tready[j] = (state!=IDLE) && !full_j. vld_user2interface[j] = !empty_j. Pop on vld&ack_interface2user.
- FIFO: no bypass. A word pushed at edge k is visible at the output after edge k (latency 1). Occupancy runs 0..FIFO_DEPTH and pointers wrap mod FIFO_DEPTH.
- Full FIFO with simultaneous pop: the push is refused because accept was already 0. Empty FIFO with simultaneous push and pop attempt: push only.
- FSM IDLE, RUN, DRAIN, all transitions on the clock edge:
  IDLE->RUN when ap_start=1. All counters clear on this transition.
  RUN->DRAIN when ap_start=0.
  DRAIN->RUN when ap_start=1.
  DRAIN->IDLE when every FIFO is empty and no push occurs this cycle; ap_done=1 for exactly that following cycle.
- DRAIN: inbound accepts held at 0. The kernel may still emit into outbound FIFOs. Both directions keep popping.
- ap_idle = (state==IDLE), registered.
- Counters increment on each push of their channel, saturate at all-ones, and hold in IDLE.

Decomposition:
- Package leaf_bridge_pkg: FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2) and a clog2 helper function.
- Sub-module stream_fifo (params WIDTH, DEPTH): sync-write FIFO with push/pop, full/empty, head data. Instantiated in generate loops, NUM_IN_PORTS+NUM_OUT_PORTS times.

Test Plan:
- Reset then ap_start=1: expect ap_idle 1->0 one cycle later. Push 0xDEAD0001 on inbound ch0 -> in_tvalid[0]=1 next cycle with in_tdata=0xDEAD0001; in_beats[0]=1.
- Backpressure, FIFO_DEPTH=4: hold in_tready[1]=0 and push 6 words -> ack drops after the 4th. Release -> words emerge in order 1..6 with no loss or duplication.
- Full plus simultaneous pop: fill ch0, then assert in_tready and vld in the same cycle -> that cycle's push refused, ack=1 the following cycle.
- Drain: drop ap_start with 3 outbound words queued and ack_interface2user=0 -> state DRAIN, inbound ack=0. Release ack -> 3 words out, then ap_done pulses once and ap_idle=1.
- Counter saturation, COUNT_BITS=4: 20 pushes -> in_beats[0]=15. Re-start -> 0.
- Async reset mid-burst: deassert ap_rst_n between edges -> outputs 0 immediately, FIFOs empty after release.

Source files
------------

// File: rtl/leaf_bridge_pkg.sv
// Shared definitions for the leaf stream bridge: controller state encoding
// and a ceiling-log2 helper used to size FIFO pointers and occupancy counters.
package leaf_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } bridge_state_t;

    // Number of bits needed to index 'value' distinct items (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/stream_fifo.sv
// Elastic FIFO for one bridge channel. Writes are synchronous; the head entry
// is read combinationally so a word pushed on one edge is presented right
// after that edge, with no same-cycle bypass from push_data to head_data.
module stream_fifo
    import leaf_bridge_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow even if the caller ignores full/empty.
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign head_data = mem[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

endmodule

// File: rtl/leaf_stream_bridge.sv
// Buffered bridge between leaf_interface vld/ack ports and the AXI-stream
// ports of an HLS kernel. Each channel gets an elastic FIFO; an ap_start
// driven IDLE/RUN/DRAIN controller gates inbound acceptance and reports
// idle/done, and per-channel saturating counters record accepted beats.
module leaf_stream_bridge
    import leaf_bridge_pkg::*;
#(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 2,
    parameter int NUM_OUT_PORTS = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int COUNT_BITS    = 16
) (
    input  logic                                  clk,
    input  logic                                  ap_rst_n,
    input  logic                                  ap_start,
    output logic                                  ap_idle,
    output logic                                  ap_done,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]               vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]               ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata,
    output logic [NUM_IN_PORTS-1:0]               in_tvalid,
    input  logic [NUM_IN_PORTS-1:0]               in_tready,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata,
    input  logic [NUM_OUT_PORTS-1:0]              out_tvalid,
    output logic [NUM_OUT_PORTS-1:0]              out_tready,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    output logic [NUM_IN_PORTS*COUNT_BITS-1:0]    in_beats,
    output logic [NUM_OUT_PORTS*COUNT_BITS-1:0]   out_beats
);

    localparam int PB = PAYLOAD_BITS;
    localparam int CB = COUNT_BITS;

    bridge_state_t             state_reg;
    logic                      idle_reg;
    logic                      done_reg;
    logic [NUM_IN_PORTS-1:0]   in_push;
    logic [NUM_IN_PORTS-1:0]   in_pop;
    logic [NUM_IN_PORTS-1:0]   in_empty;
    logic [NUM_OUT_PORTS-1:0]  out_push;
    logic [NUM_OUT_PORTS-1:0]  out_pop;
    logic [NUM_OUT_PORTS-1:0]  out_empty;
    logic                      run_start;
    logic                      all_empty;
    logic                      any_push;

    // Counters clear when a new run begins, so every run reports its own beats.
    assign run_start = (state_reg == IDLE) && ap_start;
    assign all_empty = (&in_empty) && (&out_empty);
    assign any_push  = (|in_push) || (|out_push);
    assign ap_idle   = idle_reg;
    assign ap_done   = done_reg;

    genvar gi;

    // Inbound channels: leaf_interface -> FIFO -> kernel input stream.
    generate
        for (gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
            logic          fifo_full;
            logic          fifo_empty;
            logic [CB-1:0] beats_reg;

            stream_fifo #(
                .WIDTH (PB),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (ap_rst_n),
                .push      (in_push[gi]),
                .push_data (dout_leaf_interface2user[gi*PB +: PB]),
                .pop       (in_pop[gi]),
                .head_data (in_tdata[gi*PB +: PB]),
                .full      (fifo_full),
                .empty     (fifo_empty)
            );

            // New inbound data is only taken while running; DRAIN stops intake.
            assign ack_user2interface[gi] = (state_reg == RUN) && !fifo_full;
            assign in_tvalid[gi]          = !fifo_empty;
            assign in_push[gi]            = vld_interface2user[gi] && ack_user2interface[gi];
            assign in_pop[gi]             = in_tvalid[gi] && in_tready[gi];
            assign in_empty[gi]           = fifo_empty;
            assign in_beats[gi*CB +: CB]  = beats_reg;

            // Saturating count of accepted inbound beats for this channel.
            always_ff @(posedge clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    beats_reg <= '0;
                end else if (run_start) begin
                    beats_reg <= '0;
                end else if (in_push[gi] && (beats_reg != '1)) begin
                    beats_reg <= beats_reg + CB'(1);
                end
            end
        end
    endgenerate

    // Outbound channels: kernel output stream -> FIFO -> leaf_interface.
    generate
        for (gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
            logic          fifo_full;
            logic          fifo_empty;
            logic [CB-1:0] beats_reg;

            stream_fifo #(
                .WIDTH (PB),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (ap_rst_n),
                .push      (out_push[gi]),
                .push_data (out_tdata[gi*PB +: PB]),
                .pop       (out_pop[gi]),
                .head_data (din_leaf_user2interface[gi*PB +: PB]),
                .full      (fifo_full),
                .empty     (fifo_empty)
            );

            // The kernel may keep emitting while draining, so accept in RUN and DRAIN.
            assign out_tready[gi]          = (state_reg != IDLE) && !fifo_full;
            assign vld_user2interface[gi]  = !fifo_empty;
            assign out_push[gi]            = out_tvalid[gi] && out_tready[gi];
            assign out_pop[gi]             = vld_user2interface[gi] && ack_interface2user[gi];
            assign out_empty[gi]           = fifo_empty;
            assign out_beats[gi*CB +: CB]  = beats_reg;

            // Saturating count of accepted outbound beats for this channel.
            always_ff @(posedge clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    beats_reg <= '0;
                end else if (run_start) begin
                    beats_reg <= '0;
                end else if (out_push[gi] && (beats_reg != '1)) begin
                    beats_reg <= beats_reg + CB'(1);
                end
            end
        end
    endgenerate

    // Run/drain controller with registered idle level and one-cycle done pulse.
    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= IDLE;
            idle_reg  <= 1'b1;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ap_start) begin
                        state_reg <= RUN;
                        idle_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    if (!ap_start) begin
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ap_start) begin
                        state_reg <= RUN;
                    end else if (all_empty && !any_push) begin
                        state_reg <= IDLE;
                        idle_reg  <= 1'b1;
                        done_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idle_reg  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leaf_stream_bridge.sv
// Self-checking bench for leaf_stream_bridge. A queue-based reference model
// tracks controller phase, per-channel FIFO contents and beat counts; a
// negedge monitor compares every DUT output against it, while directed and
// random stimulus runs independently.
module tb_leaf_stream_bridge;

    localparam int PB   = 32;
    localparam int NI   = 2;
    localparam int NO   = 2;
    localparam int D    = 4;
    localparam int CB   = 4;
    localparam int CMAX = (1 << CB) - 1;

    typedef logic [PB-1:0] word_t;

    logic             clk;
    logic             rst_n;
    logic             ap_start;
    logic             ap_idle;
    logic             ap_done;
    logic [NI*PB-1:0] dout;
    logic [NI-1:0]    vld_in;
    logic [NI-1:0]    ack_in;
    logic [NI*PB-1:0] in_tdata;
    logic [NI-1:0]    in_tvalid;
    logic [NI-1:0]    in_tready;
    logic [NO*PB-1:0] out_tdata;
    logic [NO-1:0]    out_tvalid;
    logic [NO-1:0]    out_tready;
    logic [NO*PB-1:0] din;
    logic [NO-1:0]    vld_out;
    logic [NO-1:0]    ack_out;
    logic [NI*CB-1:0] in_beats;
    logic [NO*CB-1:0] out_beats;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    // Reference model: 0 = idle, 1 = run, 2 = drain.
    int    m_state = 0;
    bit    m_done  = 0;
    word_t m_qin  [NI][$];
    word_t m_qout [NO][$];
    int    m_cin  [NI];
    int    m_cout [NO];

    leaf_stream_bridge #(
        .PAYLOAD_BITS  (PB),
        .NUM_IN_PORTS  (NI),
        .NUM_OUT_PORTS (NO),
        .FIFO_DEPTH    (D),
        .COUNT_BITS    (CB)
    ) dut (
        .clk                      (clk),
        .ap_rst_n                 (rst_n),
        .ap_start                 (ap_start),
        .ap_idle                  (ap_idle),
        .ap_done                  (ap_done),
        .dout_leaf_interface2user (dout),
        .vld_interface2user       (vld_in),
        .ack_user2interface       (ack_in),
        .in_tdata                 (in_tdata),
        .in_tvalid                (in_tvalid),
        .in_tready                (in_tready),
        .out_tdata                (out_tdata),
        .out_tvalid               (out_tvalid),
        .out_tready               (out_tready),
        .din_leaf_user2interface  (din),
        .vld_user2interface       (vld_out),
        .ack_interface2user       (ack_out),
        .in_beats                 (in_beats),
        .out_beats                (out_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d: got 0x%0h, expected 0x%0h", name, ch, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name, input int ch);
        checks++;
        failures++;
        $display("FAIL %s ch%0d: timed out waiting for handshake", name, ch);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_done  = 0;
        for (int i = 0; i < NI; i++) begin
            m_qin[i].delete();
            m_cin[i] = 0;
        end
        for (int j = 0; j < NO; j++) begin
            m_qout[j].delete();
            m_cout[j] = 0;
        end
    endtask

    // One clock edge of the bridge, from the rules: acceptance depends on phase
    // and fill level, transfers happen when both sides agree.
    task automatic model_step();
        bit ip [NI];
        bit ipo[NI];
        bit op [NO];
        bit opo[NO];
        bit any_push;
        bit all_empty;
        any_push  = 0;
        all_empty = 1;
        for (int i = 0; i < NI; i++) begin
            ip[i]  = vld_in[i] && (m_state == 1) && (m_qin[i].size() < D);
            ipo[i] = (m_qin[i].size() > 0) && in_tready[i];
            if (ip[i]) any_push = 1;
            if (m_qin[i].size() != 0) all_empty = 0;
        end
        for (int j = 0; j < NO; j++) begin
            op[j]  = out_tvalid[j] && (m_state != 0) && (m_qout[j].size() < D);
            opo[j] = (m_qout[j].size() > 0) && ack_out[j];
            if (op[j]) any_push = 1;
            if (m_qout[j].size() != 0) all_empty = 0;
        end
        if (m_state == 0 && ap_start) begin
            for (int i = 0; i < NI; i++) m_cin[i] = 0;
            for (int j = 0; j < NO; j++) m_cout[j] = 0;
        end else begin
            for (int i = 0; i < NI; i++) if (ip[i] && m_cin[i] < CMAX) m_cin[i]++;
            for (int j = 0; j < NO; j++) if (op[j] && m_cout[j] < CMAX) m_cout[j]++;
        end
        for (int i = 0; i < NI; i++) begin
            if (ipo[i]) void'(m_qin[i].pop_front());
            if (ip[i]) m_qin[i].push_back(dout[i*PB +: PB]);
        end
        for (int j = 0; j < NO; j++) begin
            if (opo[j]) void'(m_qout[j].pop_front());
            if (op[j]) m_qout[j].push_back(out_tdata[j*PB +: PB]);
        end
        m_done = 0;
        case (m_state)
            0: if (ap_start) m_state = 1;
            1: if (!ap_start) m_state = 2;
            2: begin
                if (ap_start) m_state = 1;
                else if (all_empty && !any_push) begin
                    m_state = 0;
                    m_done  = 1;
                end
            end
            default: m_state = 0;
        endcase
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Monitor: compare every output against the model between edges.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ap_idle", 0, 64'(ap_idle), 64'(m_state == 0));
            chk("ap_done", 0, 64'(ap_done), 64'(m_done));
            for (int i = 0; i < NI; i++) begin
                chk("ack_in", i, 64'(ack_in[i]), 64'((m_state == 1) && (m_qin[i].size() < D)));
                chk("in_tvalid", i, 64'(in_tvalid[i]), 64'(m_qin[i].size() > 0));
                if (m_qin[i].size() > 0) chk("in_tdata", i, 64'(in_tdata[i*PB +: PB]), 64'(m_qin[i][0]));
                chk("in_beats", i, 64'(in_beats[i*CB +: CB]), 64'(m_cin[i]));
            end
            for (int j = 0; j < NO; j++) begin
                chk("out_tready", j, 64'(out_tready[j]), 64'((m_state != 0) && (m_qout[j].size() < D)));
                chk("vld_out", j, 64'(vld_out[j]), 64'(m_qout[j].size() > 0));
                if (m_qout[j].size() > 0) chk("din", j, 64'(din[j*PB +: PB]), 64'(m_qout[j][0]));
                chk("out_beats", j, 64'(out_beats[j*CB +: CB]), 64'(m_cout[j]));
            end
        end
    end

    // Present one inbound word and hold it until the bridge accepts it.
    task automatic send_in(input int ch, input word_t data);
        vld_in[ch] = 1'b1;
        dout[ch*PB +: PB] = data;
        for (int t = 0; t < 100; t++) begin
            if (ack_in[ch]) begin
                @(negedge clk);
                vld_in[ch] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        vld_in[ch] = 1'b0;
        fail_timeout("send_in", ch);
    endtask

    // Kernel side emits one outbound word and holds it until accepted.
    task automatic send_out(input int ch, input word_t data);
        out_tvalid[ch] = 1'b1;
        out_tdata[ch*PB +: PB] = data;
        for (int t = 0; t < 100; t++) begin
            if (out_tready[ch]) begin
                @(negedge clk);
                out_tvalid[ch] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        out_tvalid[ch] = 1'b0;
        fail_timeout("send_out", ch);
    endtask

    initial begin
        int done_cnt;
        bit got_idle;

        rst_n      = 1'b0;
        ap_start   = 1'b0;
        dout       = '0;
        vld_in     = '0;
        in_tready  = '0;
        out_tdata  = '0;
        out_tvalid = '0;
        ack_out    = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_idle", 0, 64'(ap_idle), 64'(1));
        chk("rst_done", 0, 64'(ap_done), 64'(0));
        chk("rst_ack", 0, 64'(ack_in), 64'(0));
        chk("rst_tvalid", 0, 64'(in_tvalid), 64'(0));
        chk("rst_tready", 0, 64'(out_tready), 64'(0));
        chk("rst_vld", 0, 64'(vld_out), 64'(0));
        chk("rst_beats", 0, 64'({in_beats, out_beats}), 64'(0));
        rst_n  = 1'b1;
        chk_en = 1;
        @(negedge clk);

        // Start and first inbound word.
        chk("pre_start_idle", 0, 64'(ap_idle), 64'(1));
        ap_start = 1'b1;
        @(negedge clk);
        chk("start_idle", 0, 64'(ap_idle), 64'(0));
        send_in(0, 32'hDEAD0001);
        chk("first_tvalid", 0, 64'(in_tvalid[0]), 64'(1));
        chk("first_tdata", 0, 64'(in_tdata[31:0]), 64'(32'hDEAD0001));
        chk("first_beats", 0, 64'(in_beats[CB-1:0]), 64'(1));
        in_tready[0] = 1'b1;
        @(negedge clk);
        in_tready[0] = 1'b0;

        // Backpressure on ch1: four fit, the fifth waits until the kernel drains.
        for (int k = 1; k <= 4; k++) send_in(1, word_t'(k));
        vld_in[1] = 1'b1;
        dout[PB +: PB] = 32'd5;
        repeat (3) @(negedge clk);
        chk("bp_ack_low", 1, 64'(ack_in[1]), 64'(0));
        in_tready[1] = 1'b1;
        send_in(1, 32'd5);
        send_in(1, 32'd6);
        repeat (8) @(negedge clk);
        chk("bp_empty", 1, 64'(in_tvalid[1]), 64'(0));
        in_tready[1] = 1'b0;

        // Full ch0 with simultaneous pop: that cycle's push is refused.
        for (int k = 0; k < D; k++) send_in(0, 32'hA000_0000 + word_t'(k));
        vld_in[0] = 1'b1;
        dout[PB-1:0] = 32'h0000_0055;
        in_tready[0] = 1'b1;
        chk("full_ack", 0, 64'(ack_in[0]), 64'(0));
        @(negedge clk);
        chk("after_pop_ack", 0, 64'(ack_in[0]), 64'(1));
        @(negedge clk);
        vld_in[0] = 1'b0;
        repeat (6) @(negedge clk);
        in_tready[0] = 1'b0;

        // Drain with three outbound words held back by the leaf interface.
        for (int k = 0; k < 3; k++) send_out(0, 32'hB000_0000 + word_t'(k));
        ap_start = 1'b0;
        @(negedge clk);
        chk("drain_ack", 0, 64'(ack_in), 64'(0));
        chk("drain_not_idle", 0, 64'(ap_idle), 64'(0));
        repeat (2) @(negedge clk);
        ack_out[0] = 1'b1;
        done_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (ap_done) done_cnt++;
        end
        chk("done_pulses", 0, 64'(done_cnt), 64'(1));
        chk("drain_idle", 0, 64'(ap_idle), 64'(1));
        ack_out[0] = 1'b0;

        // Counter saturation, hold in idle, clear on restart.
        ap_start = 1'b1;
        @(negedge clk);
        in_tready[0] = 1'b1;
        for (int k = 0; k < 20; k++) send_in(0, 32'h100 + word_t'(k));
        repeat (3) @(negedge clk);
        chk("sat_beats", 0, 64'(in_beats[CB-1:0]), 64'(CMAX));
        ap_start = 1'b0;
        got_idle = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (ap_idle) begin
                got_idle = 1;
                break;
            end
        end
        if (!got_idle) fail_timeout("wait_idle", 0);
        chk("idle_hold_beats", 0, 64'(in_beats[CB-1:0]), 64'(CMAX));
        ap_start = 1'b1;
        @(negedge clk);
        chk("restart_beats", 0, 64'(in_beats[CB-1:0]), 64'(0));

        // Random traffic with occasional start/stop toggles.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NI; i++) begin
                vld_in[i]         = 1'($urandom_range(0, 1));
                dout[i*PB +: PB]  = $urandom;
                in_tready[i]      = 1'($urandom_range(0, 3) != 0);
            end
            for (int j = 0; j < NO; j++) begin
                out_tvalid[j]          = 1'($urandom_range(0, 1));
                out_tdata[j*PB +: PB]  = $urandom;
                ack_out[j]             = 1'($urandom_range(0, 2) != 0);
            end
            if ($urandom_range(0, 39) == 0) ap_start = !ap_start;
            @(negedge clk);
        end

        // Asynchronous reset between edges while FIFOs hold data.
        ap_start   = 1'b1;
        vld_in     = '1;
        in_tready  = '0;
        out_tvalid = '1;
        ack_out    = '0;
        repeat (4) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ack", 0, 64'(ack_in), 64'(0));
        chk("arst_tvalid", 0, 64'(in_tvalid), 64'(0));
        chk("arst_tready", 0, 64'(out_tready), 64'(0));
        chk("arst_vld", 0, 64'(vld_out), 64'(0));
        chk("arst_idle", 0, 64'(ap_idle), 64'(1));
        vld_in     = '0;
        out_tvalid = '0;
        ap_start   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_tvalid", 0, 64'(in_tvalid), 64'(0));
        chk("post_rst_vld", 0, 64'(vld_out), 64'(0));

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
